// File: rtl/tt_pin_pkg.sv
// Shared types for the Tiny Tapeout pin driver: command opcodes, FSM states
// and the response width.
package tt_pin_pkg;

   localparam int RSP_W = 24;

   typedef enum logic [1:0] {
      OP_WRITE_UI  = 2'b00,
      OP_WRITE_UIO = 2'b01,
      OP_READ      = 2'b10,
      OP_RESET_DUT = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_RESP    = 2'd2,
      ST_DUT_RST = 2'd3
   } state_e;

   // A uio bit conflicts when the DUT drives it and its value differs from the host's.
   function automatic logic uio_conflict(input logic [7:0] oe,
                                         input logic [7:0] dut_val,
                                         input logic [7:0] host_val);
      return |(oe & (dut_val ^ host_val));
   endfunction

endpackage

// File: rtl/tt_pin_driver.sv
// Host-side driver for the Tiny Tapeout user-project pin interface.
// Converts a valid/ready command stream into pin writes, timed reads and
// DUT resets. Only one command is in flight at a time.
module tt_pin_driver
   import tt_pin_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int RESET_CYCLES  = 10,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [7:0]       cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [RSP_W-1:0] rsp_data,
   output logic             rsp_conflict,
   output logic [7:0]       dut_ui_in,
   output logic [7:0]       dut_uio_in,
   output logic             dut_ena,
   output logic             dut_rst_n,
   input  logic [7:0]       dut_uo_out,
   input  logic [7:0]       dut_uio_out,
   input  logic [7:0]       dut_uio_oe
);

   // Reject parameter sets the wait counter cannot represent.
   if ((SETTLE_CYCLES < 1) || (RESET_CYCLES < 1) || (CNT_W < 1) || (CNT_W > 30) ||
       (SETTLE_CYCLES > (1 << CNT_W) - 1) || (RESET_CYCLES > (1 << CNT_W) - 1)) begin : g_bad_params
      $error("tt_pin_driver: SETTLE_CYCLES/RESET_CYCLES must be >=1 and fit in CNT_W bits");
   end

   state_e             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               rsp_valid_reg;
   logic [RSP_W-1:0]   rsp_data_reg;
   logic               rsp_conflict_reg;
   logic [7:0]         ui_reg;
   logic [7:0]         uio_reg;
   logic               ena_reg;
   logic               rst_n_reg;
   logic               cmd_fire;

   // ena_reg doubles as "out of reset for at least one cycle", which keeps
   // cmd_ready low for the first cycle after rst drops.
   assign cmd_ready    = (state_reg == ST_IDLE) && ena_reg;
   assign cmd_fire     = cmd_valid && cmd_ready;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_data     = rsp_data_reg;
   assign rsp_conflict = rsp_conflict_reg;
   assign dut_ui_in    = ui_reg;
   assign dut_uio_in   = uio_reg;
   assign dut_ena      = ena_reg;
   assign dut_rst_n    = rst_n_reg;

   // Command FSM, wait counter and pin/response registers.
   // The settle counter is loaded with SETTLE_CYCLES and exits on zero, so a
   // READ accepted at edge N raises rsp_valid at edge N+SETTLE_CYCLES+1.
   // The DUT-reset counter is loaded with RESET_CYCLES-1 so rst_n is low for
   // exactly RESET_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         cnt_reg          <= '0;
         rsp_valid_reg    <= 1'b0;
         rsp_data_reg     <= '0;
         rsp_conflict_reg <= 1'b0;
         ui_reg           <= '0;
         uio_reg          <= '0;
         ena_reg          <= 1'b0;
         rst_n_reg        <= 1'b0;
      end else begin
         ena_reg <= 1'b1;
         case (state_reg)
            ST_IDLE: begin
               rst_n_reg <= 1'b1;
               if (cmd_fire) begin
                  case (cmd_op_e'(cmd_op))
                     OP_WRITE_UI:  ui_reg  <= cmd_data;
                     OP_WRITE_UIO: uio_reg <= cmd_data;
                     OP_READ: begin
                        cnt_reg   <= CNT_W'(SETTLE_CYCLES);
                        state_reg <= ST_SETTLE;
                     end
                     OP_RESET_DUT: begin
                        rst_n_reg <= 1'b0;
                        cnt_reg   <= CNT_W'(RESET_CYCLES - 1);
                        state_reg <= ST_DUT_RST;
                     end
                     default: state_reg <= ST_IDLE;
                  endcase
               end
            end
            ST_SETTLE: begin
               if (cnt_reg == '0) begin
                  rsp_data_reg     <= {dut_uio_oe, dut_uio_out, dut_uo_out};
                  rsp_conflict_reg <= uio_conflict(dut_uio_oe, dut_uio_out, uio_reg);
                  rsp_valid_reg    <= 1'b1;
                  state_reg        <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            ST_DUT_RST: begin
               if (cnt_reg == '0) begin
                  rst_n_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_pin_driver.sv
// Self-checking bench for tt_pin_driver with a small stub standing in for the
// Tiny Tapeout user project. Expected values come from a reference model of
// the pin rules kept in the bench.
module tb_tt_pin_driver;
   import tt_pin_pkg::*;

   localparam int SETTLE = 2;
   localparam int RESETC = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [23:0] rsp_data;
   logic        rsp_conflict;
   logic [7:0]  dut_ui_in;
   logic [7:0]  dut_uio_in;
   logic        dut_ena;
   logic        dut_rst_n;
   logic [7:0]  dut_uo_out;
   logic [7:0]  dut_uio_out;
   logic [7:0]  dut_uio_oe;

   // Stub user project: uo_out is a nibble-swap of ui_in xor uio_in;
   // uio_out/uio_oe are set directly by the stimulus.
   logic [7:0] stub_oe;
   logic [7:0] stub_out;
   assign dut_uo_out  = {dut_ui_in[3:0], dut_ui_in[7:4]} ^ dut_uio_in;
   assign dut_uio_out = stub_out;
   assign dut_uio_oe  = stub_oe;

   int checks   = 0;
   int failures = 0;
   logic [7:0] model_ui;
   logic [7:0] model_uio;

   always #5 clk = ~clk;

   tt_pin_driver #(.SETTLE_CYCLES(SETTLE), .RESET_CYCLES(RESETC), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_conflict(rsp_conflict), .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in),
      .dut_ena(dut_ena), .dut_rst_n(dut_rst_n), .dut_uo_out(dut_uo_out),
      .dut_uio_out(dut_uio_out), .dut_uio_oe(dut_uio_oe)
   );

   // Reference: nibble swap by arithmetic, then xor with the host uio value.
   function automatic logic [7:0] ref_uo(input logic [7:0] ui, input logic [7:0] uio);
      int v;
      v = int'(ui);
      v = ((v % 16) * 16) + (v / 16);
      return 8'(v) ^ uio;
   endfunction

   function automatic logic ref_conflict(input logic [7:0] oe, input logic [7:0] o, input logic [7:0] host);
      for (int b = 0; b < 8; b++)
         if (oe[b] && (o[b] != host[b])) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 0);
      check({tag, "_conflict"}, 32'(rsp_conflict), 0);
      check({tag, "_ui"}, 32'(dut_ui_in), 0);
      check({tag, "_uio"}, 32'(dut_uio_in), 0);
      check({tag, "_ena"}, 32'(dut_ena), 0);
      check({tag, "_rst_n"}, 32'(dut_rst_n), 0);
   endtask

   // Offer a command, wait (bounded) for cmd_ready, and consume it on the next edge.
   task automatic send_cmd(input cmd_op_e op, input logic [7:0] data);
      int w;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      w = 0;
      while (!cmd_ready && w < 100) begin
         tick();
         w++;
      end
      check("cmd_accept_timeout", 32'(w < 100), 1);
      tick();
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      if (op == OP_WRITE_UI)  model_ui  = data;
      if (op == OP_WRITE_UIO) model_uio = data;
   endtask

   task automatic wait_rsp(input string tag);
      int k;
      k = 0;
      check({tag, "_busy"}, 32'(cmd_ready), 0);
      while (!rsp_valid && k < 50) begin
         tick();
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(SETTLE + 1));
      check({tag, "_data"}, 32'(rsp_data), 32'({stub_oe, stub_out, ref_uo(model_ui, model_uio)}));
      check({tag, "_conflict"}, 32'(rsp_conflict), 32'(ref_conflict(stub_oe, stub_out, model_uio)));
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, 32'(rsp_valid), 0);
      check({tag, "_idle"}, 32'(cmd_ready), 1);
   endtask

   task automatic do_read(input string tag);
      send_cmd(OP_READ, 8'h00);
      wait_rsp(tag);
      finish_rsp(tag);
   endtask

   initial begin
      logic [23:0] held;
      int lowc;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; rsp_ready = 1'b0;
      stub_oe = 8'h00; stub_out = 8'h00; model_ui = 8'h00; model_uio = 8'h00;

      // 1: reset values, then release
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      #2;
      check("release_no_ready_yet", 32'(cmd_ready), 0);
      tick();
      check("release_ena", 32'(dut_ena), 1);
      check("release_rst_n", 32'(dut_rst_n), 1);
      check("release_ready", 32'(cmd_ready), 1);
      $display("T1 reset ena=%0b rst_n=%0b ready=%0b", dut_ena, dut_rst_n, cmd_ready);

      // 2: WRITE_UI then READ
      send_cmd(OP_WRITE_UI, 8'hA5);
      check("write_ui", 32'(dut_ui_in), 32'h A5);
      check("write_ui_ready", 32'(cmd_ready), 1);
      do_read("read_a5");
      $display("T2 write_ui 0xa5 read rsp=0x%06h", rsp_data);

      // 3: back-pressure; pins change during the stall but the response must not
      send_cmd(OP_WRITE_UIO, 8'h3C);
      stub_oe = 8'hF0; stub_out = 8'h96;
      send_cmd(OP_READ, 8'h00);
      wait_rsp("stall");
      held = rsp_data;
      stub_oe = 8'h0F; stub_out = 8'h69;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_valid", 32'(rsp_valid), 1);
         check("stall_data", 32'(rsp_data), 32'(held));
         check("stall_ready", 32'(cmd_ready), 0);
      end
      finish_rsp("stall");
      $display("T3 stall 20 cycles rsp=0x%06h", held);

      // 4: RESET_DUT holds rst_n low exactly RESETC cycles, ui/uio untouched
      send_cmd(OP_RESET_DUT, 8'hFF);
      lowc = 0;
      while (!dut_rst_n && lowc < 100) begin
         lowc++;
         check("dutrst_ready", 32'(cmd_ready), 0);
         check("dutrst_ui", 32'(dut_ui_in), 32'(model_ui));
         tick();
      end
      check("dutrst_len", 32'(lowc), 32'(RESETC));
      check("dutrst_uio", 32'(dut_uio_in), 32'(model_uio));
      check("dutrst_done_ready", 32'(cmd_ready), 1);
      $display("T4 reset_dut low_cycles=%0d", lowc);

      // 5: uio conflict detection
      stub_oe = 8'h0F; stub_out = 8'h03;
      send_cmd(OP_WRITE_UIO, 8'h01);
      do_read("conflict_yes");
      check("conflict_yes_flag", 32'(rsp_conflict), 1);
      check("conflict_yes_oe", 32'(rsp_data[23:16]), 32'h0F);
      send_cmd(OP_WRITE_UIO, 8'h03);
      do_read("conflict_no");
      check("conflict_no_flag", 32'(rsp_conflict), 0);
      $display("T5 conflict checks done rsp=0x%06h", rsp_data);

      // Randomized command mix against the reference model
      for (int n = 0; n < 30; n++) begin
         int sel;
         sel = int'($urandom_range(0, 2));
         stub_oe  = 8'($urandom);
         stub_out = 8'($urandom);
         if (sel == 0) begin
            send_cmd(OP_WRITE_UI, 8'($urandom));
            check("rnd_ui", 32'(dut_ui_in), 32'(model_ui));
         end else if (sel == 1) begin
            send_cmd(OP_WRITE_UIO, 8'($urandom));
            check("rnd_uio", 32'(dut_uio_in), 32'(model_uio));
         end else begin
            send_cmd(OP_READ, 8'($urandom));
            wait_rsp("rnd_read");
            repeat ($urandom_range(0, 3)) begin
               tick();
               check("rnd_hold", 32'(rsp_valid), 1);
            end
            finish_rsp("rnd_read");
         end
         $display("RND %0d op=%0d ui=0x%02h uio=0x%02h", n, sel, dut_ui_in, dut_uio_in);
      end

      // 6a: rst in the middle of SETTLE
      send_cmd(OP_WRITE_UI, 8'h5A);
      send_cmd(OP_READ, 8'h00);
      rst = 1'b1;
      tick();
      check_reset_outputs("abort_settle");
      tick();
      rst = 1'b0;
      model_ui = 8'h00; model_uio = 8'h00;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_settle_no_rsp", 32'(rsp_valid), 0);
      end
      check("abort_settle_ena", 32'(dut_ena), 1);
      $display("T6a rst mid-settle rsp_valid=%0b", rsp_valid);

      // 6b: rst in the middle of DUT_RST
      send_cmd(OP_WRITE_UI, 8'hC3);
      send_cmd(OP_RESET_DUT, 8'h00);
      repeat (3) tick();
      check("mid_dutrst_low", 32'(dut_rst_n), 0);
      rst = 1'b1;
      tick();
      check_reset_outputs("abort_dutrst");
      rst = 1'b0;
      model_ui = 8'h00; model_uio = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_dutrst_no_rsp", 32'(rsp_valid), 0);
      end
      check("abort_dutrst_rst_n", 32'(dut_rst_n), 1);
      check("abort_dutrst_ready", 32'(cmd_ready), 1);
      $display("T6b rst mid-dut_rst rst_n=%0b ready=%0b", dut_rst_n, cmd_ready);

      // Operation after recovery
      stub_oe = 8'hAA; stub_out = 8'h55;
      send_cmd(OP_WRITE_UI, 8'h81);
      do_read("post_abort");
      $display("POST read rsp=0x%06h conflict=%0b", rsp_data, rsp_conflict);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
